// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among N_REQ byte producers. Requests are served
//   one frame at a time in round-robin order. For each grant the block sends a
//   one-cycle start pulse and the byte to the TX module, then waits for the TX
//   done pulse. A watchdog abandons a frame whose done pulse never arrives.
//
// Ports
//   i_clk       system clock (single domain)
//   i_reset     synchronous, active-high reset
//   i_req       per-requester request level
//   i_data      requester k byte at [k*DATA_W +: DATA_W]
//   o_ack       one-cycle, one-hot pulse: requester k's byte accepted
//   o_tx_start  one-cycle start pulse to the TX module
//   o_tx_data   byte to TX; valid with o_tx_start, held until the next grant
//   i_tx_done   one-cycle pulse from TX at end of frame
//   o_busy      high while a frame is in flight (START or WAIT)
//   o_grant_id  index of the last granted requester
//   o_timeout   one-cycle pulse when the watchdog expires
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  output logic [N_REQ-1:0]          o_ack,
  output logic                      o_tx_start,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_done,
  output logic                      o_busy,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic                      o_timeout
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [N_REQ-1:0]  ack_q,     ack_d;
  logic              start_q,   start_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic              busy_q,    busy_d;
  logic [GW-1:0]     grant_q,   grant_d;
  logic              timeout_q, timeout_d;
  logic [CW-1:0]     cnt_q,     cnt_d;

  logic              found;
  logic [GW-1:0]     win;
  logic [GW-1:0]     cand;
  int                idx;

  // Round-robin search: start one past the last grant and wrap upward, so the
  // last-served requester is considered last. The first set request wins.
  always_comb begin
    found = 1'b0;
    win   = grant_q;
    cand  = '0;
    idx   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx  = (int'(grant_q) + off) % N_REQ;
      cand = GW'(idx);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state logic. Every output is registered: the values computed on the
  // IDLE->START edge are exactly what the START cycle presents. The watchdog
  // counter starts at zero in START and advances on every in-flight cycle, so
  // it expires TIMEOUT_CYC cycles after the start pulse. A done pulse seen in
  // START belongs to an older frame and is ignored; in WAIT, done wins over a
  // simultaneous expiry.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    start_d   = 1'b0;
    data_d    = data_q;
    busy_d    = 1'b0;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d    = S_START;
          start_d    = 1'b1;
          ack_d[win] = 1'b1;
          data_d     = i_data[win*DATA_W +: DATA_W];
          busy_d     = 1'b1;
          grant_d    = win;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        busy_d  = 1'b1;
        cnt_d   = cnt_q + CW'(1);
      end
      S_WAIT: begin
        if (i_tx_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers. The grant pointer resets to the top index so that the
  // first search after reset begins at requester 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      ack_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      grant_q   <= GW'(N_REQ - 1);
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_busy     = busy_q;
  assign o_grant_id = grant_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter. dutA uses the default watchdog length and
//   carries the table vectors plus the long hand-written sequences; dutW uses
//   a 16-cycle watchdog for the expiry cases.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          nChecks = 0;
  int          nFails = 0;

  logic        rstA = 1'b1;
  logic [3:0]  reqA = '0;
  logic [31:0] dataA = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
  logic        doneA = 1'b0;
  logic [3:0]  ackA;
  logic        startA;
  logic [7:0]  txdA;
  logic        busyA;
  logic [1:0]  grantA;
  logic        toA;

  logic        rstW = 1'b1;
  logic [3:0]  reqW = '0;
  logic [31:0] dataW = {8'h00, 8'h00, 8'h00, 8'h5A};
  logic        doneW = 1'b0;
  logic [3:0]  ackW;
  logic        startW;
  logic [7:0]  txdW;
  logic        busyW;
  logic [1:0]  grantW;
  logic        toW;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] ack;
    logic       start;
    logic [7:0] data;
    logic       busy;
    logic [1:0] grant;
  } vec_t;

  vec_t vecs [0:26];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(2048)) dutA (
    .i_clk(clk), .i_reset(rstA), .i_req(reqA), .i_data(dataA),
    .o_ack(ackA), .o_tx_start(startA), .o_tx_data(txdA), .i_tx_done(doneA),
    .o_busy(busyA), .o_grant_id(grantA), .o_timeout(toA)
  );

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dutW (
    .i_clk(clk), .i_reset(rstW), .i_req(reqW), .i_data(dataW),
    .o_ack(ackW), .o_tx_start(startW), .o_tx_data(txdW), .i_tx_done(doneW),
    .o_busy(busyW), .o_grant_id(grantW), .o_timeout(toW)
  );

  // Drive dutA inputs, let one rising edge pass, and settle 1 time unit after it.
  task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic done);
    rstA  = rst;
    reqA  = req;
    doneA = done;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One comparison: counts it, reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every dutA output against one expected set.
  task automatic checkA(input string tag, input logic [3:0] ack, input logic start,
                        input logic [7:0] data, input logic busy, input logic [1:0] grant);
    checkOutput({tag, ".ack"},     32'(ackA),   32'(ack));
    checkOutput({tag, ".start"},   32'(startA), 32'(start));
    checkOutput({tag, ".data"},    32'(txdA),   32'(data));
    checkOutput({tag, ".busy"},    32'(busyA),  32'(busy));
    checkOutput({tag, ".grant"},   32'(grantA), 32'(grant));
    checkOutput({tag, ".timeout"}, 32'(toA),    32'h0);
  endtask

  // Hard stop in case something waits forever.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int s;
    int prevStart;
    int seen;
    logic busyHeld;

    // rst, req, done | ack, start, data, busy, grant
    vecs[0]  = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3};
    vecs[1]  = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3};
    vecs[2]  = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3};
    vecs[3]  = {1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3};
    vecs[4]  = {1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3};
    vecs[5]  = {1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0};
    vecs[6]  = {1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0};
    vecs[7]  = {1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0};
    vecs[8]  = {1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0};
    vecs[9]  = {1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'hB1, 1'b1, 2'd1};
    vecs[10] = {1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'hB1, 1'b1, 2'd1};
    vecs[11] = {1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'hB1, 1'b1, 2'd1};
    vecs[12] = {1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hB1, 1'b1, 2'd1};
    vecs[13] = {1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hB1, 1'b0, 2'd1};
    vecs[14] = {1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hB1, 1'b0, 2'd1};
    vecs[15] = {1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hC2, 1'b1, 2'd2};
    vecs[16] = {1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 8'hC2, 1'b1, 2'd2};
    vecs[17] = {1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 8'hC2, 1'b0, 2'd2};
    vecs[18] = {1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0};
    vecs[19] = {1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0};
    vecs[20] = {1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0};
    vecs[21] = {1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 8'hB1, 1'b1, 2'd1};
    vecs[22] = {1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 8'hB1, 1'b1, 2'd1};
    vecs[23] = {1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 8'hB1, 1'b0, 2'd1};
    vecs[24] = {1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0};
    vecs[25] = {1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0};
    vecs[26] = {1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0};

    // Table: reset, idle, single grant, stale done, withdraw, wrap-around.
    for (int i = 0; i <= 26; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].done);
      checkA($sformatf("vec%0d", i), vecs[i].ack, vecs[i].start, vecs[i].data,
             vecs[i].busy, vecs[i].grant);
    end

    // Idle for 20 cycles: no start may appear.
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0);
      if (startA) seen++;
    end
    checkOutput("idle20.starts", 32'(seen), 32'd0);

    // Single request, done 100 cycles after the start.
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkA("single.start", 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0);
    s = cyc;
    busyHeld = 1'b1;
    while (cyc < s + 100) begin
      applyStimulus(1'b0, 4'b0000, 1'b0);
      if (!busyA) busyHeld = 1'b0;
    end
    checkOutput("single.busy_held", 32'(busyHeld), 32'd1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkA("single.after_done", 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0);

    // Round-robin with all four requesting; done 50 cycles after each start.
    dataA = {8'h13, 8'h12, 8'h11, 8'h10};
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkA("rr.reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3);
    prevStart = 0;
    for (int f = 0; f < 5; f++) begin
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        applyStimulus(1'b0, 4'b1111, 1'b0);
        if (startA) seen = 1;
      end
      checkOutput($sformatf("rr%0d.start_seen", f), 32'(seen), 32'd1);
      checkOutput($sformatf("rr%0d.data", f), 32'(txdA), 32'(8'h10 + (f % 4)));
      checkOutput($sformatf("rr%0d.ack", f), 32'(ackA), 32'(1 << (f % 4)));
      if (f > 0)
        checkOutput($sformatf("rr%0d.spacing", f), 32'(cyc - prevStart), 32'd52);
      prevStart = cyc;
      if (f < 4) begin
        while (cyc < prevStart + 50) applyStimulus(1'b0, 4'b1111, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput($sformatf("rr%0d.idle_busy", f), 32'(busyA), 32'd0);
      end
    end

    // Reset while a frame is in flight, with requester 1 pending.
    applyStimulus(1'b0, 4'b0010, 1'b0);
    checkOutput("midrst.in_wait", 32'(busyA), 32'd1);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkA("midrst.r1", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkA("midrst.r2", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    checkA("midrst.served", 4'b0010, 1'b1, 8'h11, 1'b1, 2'd1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("midrst.done_busy", 32'(busyA), 32'd0);

    // Watchdog on dutW: no done, expiry 16 cycles after the start pulse.
    rstW = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    reqW = 4'b0001;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("wd.start", 32'(startW), 32'd1);
    checkOutput("wd.data", 32'(txdW), 32'h5A);
    s = cyc;
    reqW = 4'b0000;
    seen = 0;
    busyHeld = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0);
      if (toW) seen = 1;
      else if (!busyW) busyHeld = 1'b0;
    end
    checkOutput("wd.timeout_seen", 32'(seen), 32'd1);
    checkOutput("wd.timeout_cycle", 32'(cyc - s), 32'd16);
    checkOutput("wd.busy_before", 32'(busyHeld), 32'd1);
    checkOutput("wd.busy_at_to", 32'(busyW), 32'd0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("wd.pulse_width", 32'(toW), 32'd0);

    // Done in the very cycle the watchdog would expire: counts as done.
    reqW = 4'b0001;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("wd2.start", 32'(startW), 32'd1);
    s = cyc;
    reqW = 4'b0000;
    while (cyc < s + 15) applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("wd2.busy_pre", 32'(busyW), 32'd1);
    doneW = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    doneW = 1'b0;
    checkOutput("wd2.no_timeout", 32'(toW), 32'd0);
    checkOutput("wd2.busy_post", 32'(busyW), 32'd0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("wd2.no_timeout_late", 32'(toW), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single UART transmitter among N_REQ byte producers (test generators, status reporters, loopback echo).
- Each producer raises a request with a byte. The block grants one producer at a time in round-robin order, issues a one-cycle start pulse with the byte to the TX module, and waits for the TX done pulse before the next grant.
- A watchdog recovers from a transmitter that never reports done.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width sent to TX.
- TIMEOUT_CYC, 2048, max cycles to wait for i_tx_done before abandoning a frame (>=16).

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_reset  input  1  reset, synchronous, active-high.
- i_req  input  N_REQ  per-requester request level.
- i_data  input  N_REQ*DATA_W  requester k byte at bits [k*DATA_W +: DATA_W].
- o_ack  output  N_REQ  one-cycle pulse: requester k's byte accepted.
- o_tx_start  output  1  one-cycle start pulse to TX module.
- o_tx_data  output  DATA_W  byte to TX; valid with o_tx_start, held until next grant.
- i_tx_done  input  1  one-cycle pulse from TX at end of frame.
- o_busy  output  1  high while a frame is in flight (START or WAIT).
- o_grant_id  output  $clog2(N_REQ)  index of the last granted requester.
- o_timeout  output  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - o_ack = 0, o_tx_start = 0, o_tx_data = 0, o_busy = 0, o_timeout = 0.
  - o_grant_id = N_REQ-1, so requester 0 has top priority first.
  - FSM enters IDLE; watchdog counter = 0.
- Reset mid-frame: applies the same values on the next edge. The in-flight frame is forgotten and no ack is re-issued.
- FSM states:
  - IDLE: on any i_req bit high, select the winner k and go to START. Otherwise stay.
  - START: registered outputs for this cycle are o_tx_start = 1, o_tx_data = i_data[k] (captured at the IDLE->START edge), o_ack[k] = 1, o_busy = 1, o_grant_id = k. Next state is always WAIT.
  - WAIT: o_busy = 1 and the watchdog counts up each cycle.
    - On i_tx_done = 1: go to IDLE and clear the counter.
    - If the counter reaches TIMEOUT_CYC-1 without done: pulse o_timeout for 1 cycle, go to IDLE, clear the counter.
- Arbitration (round-robin):
  - Search starts at (o_grant_id+1) mod N_REQ and wraps upward.
  - The first set i_req bit wins; pointer wrap is modulo N_REQ.
- Latency:
  - Request seen in IDLE at cycle t -> o_tx_start and o_ack high in cycle t+1.
  - i_tx_done in cycle d -> IDLE in d+1 -> earliest next start in d+2.
- i_tx_done handling:
  - Ignored in IDLE.
  - Ignored in the START cycle (stale done from a previous frame).
  - Done coinciding with watchdog expiry counts as done: no o_timeout.
- Requester rules:
  - Hold i_req high and i_data stable until o_ack.
  - May drop i_req before ack (withdraw); no grant is issued for a withdrawn request.
  - Should drop i_req in the cycle after ack. A request still high in IDLE is treated as a new byte.
- o_tx_data holds its value after START until the next START.
- o_ack is one-hot or zero; never more than one bit set.
- Multiple simultaneous requests are served one per frame, in rotation order. No requester waits more than N_REQ-1 frames while its request is held.

Test Plan:
- Reset then idle: assert i_reset for 3 cycles, release, no requests for 20 cycles -> all outputs 0 except o_grant_id = 3; no o_tx_start.
- Single request: i_req = 0001, data0 = 0xA5 at cycle t -> cycle t+1 has o_tx_start = 1, o_tx_data = 0xA5, o_ack = 0001, o_busy = 1. Drive i_tx_done 100 cycles later -> o_busy = 0 next cycle.
- Round-robin fairness: hold i_req = 1111, data k = 0x10+k, pulse done 50 cycles after each start -> bytes 0x10, 0x11, 0x12, 0x13, 0x10 in that order; starts spaced exactly 52 cycles (done + 2).
- Starvation/wrap: o_grant_id = 2, i_req = 0011 -> grant 0 then 1, then 0 again if still requesting; requester 3 is never acked.
- Done edge cases:
  - i_tx_done in the START cycle -> ignored, FSM stays in WAIT.
  - i_tx_done while IDLE with no req -> no effect.
  - Withdraw: i_req[2] high then low before grant -> no o_ack[2].
- Watchdog and reset: TIMEOUT_CYC = 16, grant with no done -> o_timeout pulses 16 cycles after START and the FSM returns to IDLE. Separately, assert i_reset in WAIT -> the next edge restores all reset values and a pending req is served only after reset release.
